// File: rtl/playback_scheduler.sv
// playback_scheduler: records key/duration entries into a shared RAM and plays them back on Tick; LOOP_PLAY_EN restarts playback instead of finishing
module playback_scheduler #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12,
  parameter int KEY_W  = 8
) (
  input  logic              RCLK,
  input  logic              Rst,
  input  logic              RecordEn,
  input  logic              PlayEn,
  input  logic              RecWriteEn,
  input  logic [ADDR_W-1:0] RecAddress,
  input  logic [DATA_W-1:0] RecSignal,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemDin,
  input  logic [DATA_W-1:0] MemDout,
  input  logic              Tick,
  output logic [KEY_W-1:0]  PlayKey,
  output logic              Playing,
  output logic              Done,
  output logic [ADDR_W-1:0] LastAddr
);
  typedef enum logic [2:0] {IDLE, REC, FETCH, WAIT, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [3:0] dur, dur_n;
  logic [KEY_W-1:0] key_n;
  logic last_entry;
  assign last_entry = ptr == LastAddr;
  // Recorder owns the RAM port in REC; otherwise the play pointer reads it
  assign MemWE   = state == REC && RecWriteEn;
  assign MemAddr = state == REC ? RecAddress : ptr;
  assign MemDin  = state == REC ? RecSignal : '0;
  assign Playing = state == HOLD;
  assign Done    = state == DONE;
  // Next-state, pointer and duration counter; RecordEn preempts everything
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    dur_n = dur;
    if (RecordEn) state_n = REC;
    else case (state)
      IDLE: if (PlayEn) begin
        state_n = LastAddr != '0 ? FETCH : DONE;
        ptr_n = LastAddr != '0 ? ADDR_W'(1) : ptr;
      end
      FETCH: state_n = PlayEn ? WAIT : IDLE;
      WAIT: begin
        state_n = PlayEn ? HOLD : IDLE;
        dur_n = PlayEn ? MemDout[3:0] : dur;
      end
      HOLD: if (!PlayEn) state_n = IDLE;
      else if (Tick) begin
        if (dur != 4'd0) dur_n = dur - 4'd1;
        else if (!last_entry) begin
          ptr_n = ptr + ADDR_W'(1);
          state_n = FETCH;
        end else begin
`ifdef LOOP_PLAY_EN
          ptr_n = ADDR_W'(1);
          state_n = FETCH;
`else
          state_n = DONE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    key_n = (state_n inside {IDLE, REC, DONE}) ? '0 :
            (state == WAIT && state_n == HOLD) ? MemDout[4 +: KEY_W] : PlayKey;
  end
  // State and datapath registers; LastAddr only tracks recorder writes
  always_ff @(posedge RCLK) begin
    if (Rst) begin
      state <= IDLE;
      ptr <= '0;
      dur <= '0;
      PlayKey <= '0;
      LastAddr <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      dur <= dur_n;
      PlayKey <= key_n;
      if (MemWE) LastAddr <= RecAddress;
    end
  end
endmodule

// File: tb/tb_playback_scheduler.sv
// tb_playback_scheduler: directed checks of record, playback, preemption and reset
module tb_playback_scheduler;
  logic RCLK = 0, Rst = 1, RecordEn = 0, PlayEn = 0, RecWriteEn = 0, Tick = 0;
  logic [10:0] RecAddress = 0, MemAddr, LastAddr;
  logic [11:0] RecSignal = 0, MemDin, MemDout;
  logic [7:0] PlayKey;
  logic MemWE, Playing, Done;
  logic [11:0] mem [0:2047];
  int errors = 0, checks = 0;
  playback_scheduler dut (
    .RCLK(RCLK), .Rst(Rst), .RecordEn(RecordEn), .PlayEn(PlayEn),
    .RecWriteEn(RecWriteEn), .RecAddress(RecAddress), .RecSignal(RecSignal),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemDin(MemDin), .MemDout(MemDout),
    .Tick(Tick), .PlayKey(PlayKey), .Playing(Playing), .Done(Done), .LastAddr(LastAddr)
  );
  always #5 RCLK = ~RCLK;
  always @(posedge RCLK) begin
    if (MemWE) mem[MemAddr] <= MemDin;
    MemDout <= mem[MemAddr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge RCLK);
    #2;
  endtask
  task automatic to_hold();
    PlayEn = 1;
    step();
    step();
    step();
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    step();
    Rst = 0;
    #1;
    chk("rst_key", PlayKey, 0);
    chk("rst_playing", Playing, 0);
    chk("rst_done", Done, 0);
    chk("rst_we", MemWE, 0);
    chk("rst_last", LastAddr, 0);
    chk("rst_addr", MemAddr, 0);
    RecordEn = 1;
    step();
    RecWriteEn = 1; RecAddress = 1; RecSignal = 12'h412;
    #1;
    chk("rec_we", MemWE, 1);
    chk("rec_addr", MemAddr, 1);
    chk("rec_din", MemDin, 12'h412);
    step();
    chk("rec_last1", LastAddr, 1);
    RecAddress = 2; RecSignal = 12'h420;
    step();
    chk("rec_last2", LastAddr, 2);
    RecWriteEn = 0;
    #1;
    chk("rec_we_off", MemWE, 0);
    RecordEn = 0;
    step();
    chk("idle_key", PlayKey, 0);
    to_hold();
    chk("e1_key", PlayKey, 8'h41);
    chk("e1_playing", Playing, 1);
    for (int t = 1; t <= 2; t++) begin
      Tick = 1; step(); Tick = 0; step();
      chk("e1_hold_key", PlayKey, 8'h41);
      chk("e1_hold_playing", Playing, 1);
    end
    Tick = 1; step(); Tick = 0;
    chk("e2_fetch_playing", Playing, 0);
    chk("e2_fetch_addr", MemAddr, 2);
    Tick = 1;
    step();
    Tick = 0;
    step();
    chk("e2_key", PlayKey, 8'h42);
    chk("e2_wait_tick_ignored", Playing, 1);
    Tick = 1;
    step();
    Tick = 0;
`ifdef LOOP_PLAY_EN
    chk("loop_done", Done, 0);
    chk("loop_addr", MemAddr, 1);
    PlayEn = 0;
    step();
`else
    chk("end_done", Done, 1);
    chk("end_key", PlayKey, 0);
    PlayEn = 0;
    step();
    chk("end_done_once", Done, 0);
`endif
    chk("end_idle_key", PlayKey, 0);
    to_hold();
    chk("pre_key", PlayKey, 8'h41);
    RecordEn = 1;
    step();
    chk("pre_key0", PlayKey, 0);
    chk("pre_done", Done, 0);
    chk("pre_playing", Playing, 0);
    RecWriteEn = 1; RecAddress = 2; RecSignal = 12'h420;
    #1;
    chk("pre_we", MemWE, 1);
    chk("pre_addr", MemAddr, 2);
    step();
    RecWriteEn = 0; RecordEn = 0; PlayEn = 0;
    step();
    chk("keep_last", LastAddr, 2);
    to_hold();
    chk("abort_key_hold", PlayKey, 8'h41);
    PlayEn = 0;
    step();
    chk("abort_key", PlayKey, 0);
    chk("abort_done", Done, 0);
    chk("abort_playing", Playing, 0);
    to_hold();
    Rst = 1;
    step();
    Rst = 0;
    #1;
    chk("mid_rst_last", LastAddr, 0);
    chk("mid_rst_key", PlayKey, 0);
    chk("mid_rst_playing", Playing, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_we", MemWE, 0);
    chk("mid_rst_addr", MemAddr, 0);
    step();
    chk("empty_done", Done, 1);
    chk("empty_key", PlayKey, 0);
    chk("empty_we", MemWE, 0);
    PlayEn = 0;
    step();
    chk("empty_done_once", Done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
